count_capture_fifo: RTL and testbench

//   Downstream consumer of the 8-bit counter output (o_count/count_valid).
//   On a capture strobe, snapshots the current count into a small FIFO.

---
 rtl/count_capture_fifo.sv | 177 +++++++++++++++++
 tb/tb_count_capture_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_capture_fifo.sv
// count_capture_fifo
//   Snapshots an 8-bit counter value into a small FIFO on a capture strobe
//   and drains the FIFO through a valid/ready stream. Captures that arrive
//   while the FIFO is full are dropped and counted so software can detect
//   lost samples.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   i_count      counter value to capture
//   count_valid  qualifier for i_count; captures are ignored while low
//   i_capture    capture strobe, sampled every cycle
//   i_clr        synchronous flush of FIFO contents, flags and baseline
//   o_data       FIFO head entry (0 while empty)
//   o_valid      FIFO not empty
//   i_ready      consumer accepts o_data when o_valid & i_ready
//   o_level      current entry count, 0..DEPTH
//   o_full       o_level == DEPTH
//   o_overflow   sticky flag, at least one capture dropped
//   o_drop_cnt   dropped-capture count, saturating at 255
//
// Configuration
//   CAPTURE_DELTA_EN  when defined, each entry stores the difference from the
//                     previously written capture instead of the raw count.

module count_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_count,
    input  logic             count_valid,
    input  logic             i_capture,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [AW:0]      o_level,
    output logic             o_full,
    output logic             o_overflow,
    output logic [7:0]       o_drop_cnt
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        valid_q, valid_d;
    logic        full_q, full_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic             push;
    logic             pop;
    logic             ptr_full;
    logic             wr_en;
    logic             drop;
    logic [WIDTH-1:0] wr_data;

`ifdef CAPTURE_DELTA_EN
    logic [WIDTH-1:0] baseline_q, baseline_d;
`endif

    // Handshake decode. Full comes from the pointer MSB compare; a full FIFO
    // still accepts a push when the head is popped in the same cycle.
    always_comb begin
        push     = i_capture & count_valid;
        pop      = valid_q & i_ready;
        ptr_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_en    = push & (~ptr_full | pop) & ~i_clr;
        drop     = push & ptr_full & ~pop & ~i_clr;
    end

    // Entry value: raw count, or modulo difference from the last written capture.
`ifdef CAPTURE_DELTA_EN
    always_comb begin
        wr_data    = i_count - baseline_q;
        baseline_d = baseline_q;
        if (i_clr) begin
            baseline_d = '0;
        end else if (wr_en) begin
            baseline_d = i_count;
        end
    end
`else
    always_comb begin
        wr_data = i_count;
    end
`endif

    // Next-state for pointers and flags; level/valid/full are derived from the
    // next pointers so they stay registered outputs.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (i_clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end
        level_d = wr_ptr_d - rd_ptr_d;
        valid_d = (wr_ptr_d != rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef CAPTURE_DELTA_EN
    // Delta baseline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baseline_q <= '0;
        end else begin
            baseline_q <= baseline_d;
        end
    end
`endif

    // Storage array needs no reset: o_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        o_data     = valid_q ? mem_q[rd_ptr_q[AW-1:0]] : '0;
        o_valid    = valid_q;
        o_level    = level_q;
        o_full     = full_q;
        o_overflow = overflow_q;
        o_drop_cnt = drop_cnt_q;
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// tb_count_capture_fifo
//   Self-checking bench for count_capture_fifo: a table of directed vectors,
//   a randomized phase against a queue-based reference model, and hand-written
//   sequences for drop-counter saturation and asynchronous mid-stream reset.

`ifdef CAPTURE_DELTA_EN
`define TB_SEL(a, d) (d)
`else
`define TB_SEL(a, d) (a)
`endif

module tb_count_capture_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] i_count;
    logic             count_valid;
    logic             i_capture;
    logic             i_clr;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             i_ready;
    logic [AW:0]      o_level;
    logic             o_full;
    logic             o_overflow;
    logic [7:0]       o_drop_cnt;

    int checks = 0;
    int errors = 0;

    count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_count     (i_count),
        .count_valid (count_valid),
        .i_capture   (i_capture),
        .i_clr       (i_clr),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_level     (o_level),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_drop_cnt  (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of stored entries plus the flags.
    logic [7:0] m_q [$];
    bit         m_ovf;
    int         m_drop;
    logic [7:0] m_base;

    task automatic modelReset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        m_base = 8'h00;
    endtask

    task automatic modelStep(input bit cap, input bit cv, input logic [7:0] cnt,
                             input bit clr, input bit rdy);
        int         sz;
        bit         pop;
        bit         push;
        logic [7:0] v;
        sz   = m_q.size();
        pop  = (sz > 0) && rdy;
        push = cap && cv;
        if (clr) begin
            modelReset();
        end else begin
            if (push && sz == DEPTH && !pop) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            if (pop) void'(m_q.pop_front());
            if (push && (sz < DEPTH || pop)) begin
`ifdef CAPTURE_DELTA_EN
                v      = cnt - m_base;
                m_base = cnt;
`else
                v = cnt;
`endif
                m_q.push_back(v);
            end
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int lvl, input bit vld,
                               input logic [7:0] data, input bit full,
                               input bit ovf, input int drop);
        cmp({tag, " o_level"},    int'(o_level),    lvl);
        cmp({tag, " o_valid"},    int'(o_valid),    int'(vld));
        cmp({tag, " o_data"},     int'(o_data),     int'(data));
        cmp({tag, " o_full"},     int'(o_full),     int'(full));
        cmp({tag, " o_overflow"}, int'(o_overflow), int'(ovf));
        cmp({tag, " o_drop_cnt"}, int'(o_drop_cnt), drop);
    endtask

    task automatic checkModel(input string tag);
        int sz;
        sz = m_q.size();
        checkOutput(tag, sz, sz > 0, (sz > 0) ? m_q[0] : 8'h00,
                    sz == DEPTH, m_ovf, m_drop);
    endtask

    // Drive one cycle of inputs, advance the model, and sample 1ns after the edge.
    task automatic applyStimulus(input bit cap, input bit cv, input logic [7:0] cnt,
                                 input bit clr, input bit rdy);
        i_capture   = cap;
        count_valid = cv;
        i_count     = cnt;
        i_clr       = clr;
        i_ready     = rdy;
        modelStep(cap, cv, cnt, clr, rdy);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         cap;
        bit         cv;
        logic [7:0] cnt;
        bit         clr;
        bit         rdy;
        int         lvl;
        bit         vld;
        logic [7:0] data;
        bit         full;
        bit         ovf;
        int         drop;
    } vec_t;

    vec_t vecs [20];

    initial begin
        logic [7:0] head10;
        head10 = `TB_SEL(8'h10, 8'h0B);

        vecs[0]  = '{1, 1, 8'h05, 0, 1,  1, 1, 8'h05, 0, 0, 0};
        vecs[1]  = '{1, 0, 8'h06, 0, 1,  0, 0, 8'h00, 0, 0, 0};
        vecs[2]  = '{1, 1, 8'h10, 0, 0,  1, 1, head10, 0, 0, 0};
        for (int i = 3; i <= 9; i++) begin
            vecs[i] = '{1, 1, 8'(8'h0E + i), 0, 0, i - 1, 1, head10, i == 9, 0, 0};
        end
        vecs[10] = '{1, 1, 8'h18, 0, 0,  8, 1, head10, 1, 1, 1};
        vecs[11] = '{1, 1, 8'h19, 0, 0,  8, 1, head10, 1, 1, 2};
        vecs[12] = '{1, 0, 8'h1A, 0, 0,  8, 1, head10, 1, 1, 2};
        vecs[13] = '{1, 1, 8'h40, 0, 1,  8, 1, `TB_SEL(8'h11, 8'h01), 1, 1, 2};
        vecs[14] = '{0, 1, 8'h41, 0, 1,  7, 1, `TB_SEL(8'h12, 8'h01), 0, 1, 2};
        vecs[15] = '{1, 1, 8'h50, 1, 1,  0, 0, 8'h00, 0, 0, 0};
        vecs[16] = '{1, 1, 8'hF0, 0, 0,  1, 1, 8'hF0, 0, 0, 0};
        vecs[17] = '{1, 1, 8'h10, 0, 0,  2, 1, 8'hF0, 0, 0, 0};
        vecs[18] = '{0, 1, 8'h11, 0, 1,  1, 1, `TB_SEL(8'h10, 8'h20), 0, 0, 0};
        vecs[19] = '{0, 1, 8'h12, 0, 1,  0, 0, 8'h00, 0, 0, 0};

        reset       = 1'b1;
        i_count     = 8'h00;
        count_valid = 1'b0;
        i_capture   = 1'b0;
        i_clr       = 1'b0;
        i_ready     = 1'b0;
        modelReset();

        #12;
        checkOutput("reset", 0, 0, 8'h00, 0, 0, 0);
        #8;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].cap, vecs[i].cv, vecs[i].cnt, vecs[i].clr, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].vld, vecs[i].data,
                        vecs[i].full, vecs[i].ovf, vecs[i].drop);
        end

        // Randomized traffic: first half starves the consumer to exercise full/drop,
        // second half drains readily.
        for (int i = 0; i < 600; i++) begin
            bit rdy;
            rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                          8'($urandom_range(0, 255)), $urandom_range(0, 99) == 0, rdy);
            checkModel($sformatf("rand%0d", i));
        end

        // Drop counter saturation: fill, then keep capturing with no consumer.
        applyStimulus(0, 1, 8'h00, 1, 0);
        checkModel("sat_clr");
        for (int i = 0; i < 266; i++) begin
            applyStimulus(1, 1, 8'(8'h60 + i), 0, 0);
            checkModel($sformatf("sat%0d", i));
        end
        cmp("sat drop_cnt", int'(o_drop_cnt), 255);
        cmp("sat level", int'(o_level), 8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 8'h00, 0, 1);
            checkModel($sformatf("pop%0d", i));
        end
        cmp("pre-reset level", int'(o_level), 5);

        // Asynchronous reset mid-cycle: outputs must clear before the next edge.
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("async_reset", 0, 0, 8'h00, 0, 0, 0);
        #3;
        reset = 1'b0;

        applyStimulus(1, 1, 8'h33, 0, 0);
        checkOutput("post_reset_push", 1, 1, 8'h33, 0, 0, 0);
        applyStimulus(0, 1, 8'h34, 0, 1);
        checkModel("post_reset_pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
